// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: FSM state encoding and
// default widths reused by the multiplier-array integration.
package product_accumulator_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  localparam int DEF_PROD_W = 8;
  localparam int DEF_ACC_W  = 16;
  localparam int DEF_COUNT  = 4;
  localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/product_accumulator.sv
// Groups multiplier products into wide sums and hands each closed group
// downstream through a registered valid/ready result stage.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int COUNT  = DEF_COUNT,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               oflow_q, oflow_d;

  logic               accept;
  logic [ACC_W:0]     sum_ext;
  logic [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt_next;
  logic               ovf_next;
  logic               close_group;

  // Ready depends on registered state only, so out_ready never reaches in_ready.
  assign in_ready     = (state_q == ST_ACCUM);
  assign out_valid    = (state_q == ST_HOLD);
  assign out_sum      = sum_q;
  assign out_count    = count_q;
  assign out_overflow = oflow_q;

  assign accept   = in_valid && in_ready;
  assign sum_ext  = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
  assign acc_next = accept ? sum_ext[ACC_W-1:0] : acc_q;
  assign cnt_next = cnt_q + CNT_W'(accept);
  assign ovf_next = ovf_q | (accept & sum_ext[ACC_W]);

  // An empty group is never closed: a lone flush with nothing counted is dropped.
  assign close_group = (accept && (cnt_q == CNT_W'(COUNT - 1))) ||
                       (flush && ((cnt_q != '0) || accept));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    count_d = count_q;
    oflow_d = oflow_q;

    unique case (state_q)
      ST_ACCUM: begin
        acc_d = acc_next;
        cnt_d = cnt_next;
        ovf_d = ovf_next;
        if (close_group) begin
          state_d = ST_HOLD;
          sum_d   = acc_next;
          count_d = cnt_next;
          oflow_d = ovf_next;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      oflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      oflow_q <= oflow_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: a default instance and a narrow ACC_W=10/COUNT=8
// instance share one random stimulus stream, each tracked by a sum model.
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_product = '0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, out_overflow_a;
  logic [15:0] out_sum_a;
  logic [7:0]  out_count_a;
  logic        in_ready_b, out_valid_b, out_overflow_b;
  logic [9:0]  out_sum_b;
  logic [7:0]  out_count_b;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  product_accumulator dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_product(in_product), .flush(flush), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_sum(out_sum_a), .out_count(out_count_a),
    .out_overflow(out_overflow_a)
  );

  product_accumulator #(.PROD_W(8), .ACC_W(10), .COUNT(8), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_product(in_product), .flush(flush), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_sum(out_sum_b), .out_count(out_count_b),
    .out_overflow(out_overflow_b)
  );

  // Model: each instance holds the exact (unwrapped) running total of its group.
  int lim  [2] = '{4, 8};
  int accw [2] = '{16, 10};
  bit hold [2];
  int tsum [2];
  int n    [2];
  int exp_sum [2];
  int exp_cnt [2];
  bit exp_ovf [2];

  logic [31:0] o_sum [2];
  logic [31:0] o_cnt [2];
  logic        o_ovf [2];
  logic        o_vld [2];
  logic        o_rdy [2];

  always_comb begin
    o_sum[0] = 32'(out_sum_a);   o_sum[1] = 32'(out_sum_b);
    o_cnt[0] = 32'(out_count_a); o_cnt[1] = 32'(out_count_b);
    o_ovf[0] = out_overflow_a;   o_ovf[1] = out_overflow_b;
    o_vld[0] = out_valid_a;      o_vld[1] = out_valid_b;
    o_rdy[0] = in_ready_a;       o_rdy[1] = in_ready_b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    if (reset) begin
      hold[k] = 1'b0; tsum[k] = 0; n[k] = 0;
    end else if (hold[k]) begin
      if (out_ready) begin
        hold[k] = 1'b0; tsum[k] = 0; n[k] = 0;
      end
    end else begin
      if (in_valid) begin
        tsum[k] += int'(in_product);
        n[k]++;
      end
      if (n[k] == lim[k] || (flush && n[k] > 0)) begin
        hold[k]    = 1'b1;
        exp_sum[k] = tsum[k] % (1 << accw[k]);
        exp_cnt[k] = n[k];
        exp_ovf[k] = (tsum[k] >= (1 << accw[k]));
      end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("m%0d_in_ready", k), 32'(o_rdy[k]), 32'(!hold[k]));
        check($sformatf("m%0d_out_valid", k), 32'(o_vld[k]), 32'(hold[k]));
        if (hold[k]) begin
          check($sformatf("m%0d_out_sum", k), o_sum[k], 32'(exp_sum[k]));
          check($sformatf("m%0d_out_count", k), o_cnt[k], 32'(exp_cnt[k]));
          check($sformatf("m%0d_out_overflow", k), 32'(o_ovf[k]), 32'(exp_ovf[k]));
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [7:0] p, input bit f, input bit r, input bit rst);
    in_valid = v; in_product = p; flush = f; out_ready = r; reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk_en = 1'b1;
    settle();
    check("rst_out_valid", 32'(out_valid_a), 0);
    check("rst_in_ready", 32'(in_ready_a), 1);
    check("rst_out_sum", 32'(out_sum_a), 0);
    check("rst_out_count", 32'(out_count_a), 0);
    check("rst_out_overflow", 32'(out_overflow_a), 0);

    // Full group of four.
    cyc(1, 15, 0, 0, 0);
    cyc(1, 225, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 100, 0, 0, 0);
    settle();
    check("g1_valid", 32'(out_valid_a), 1);
    check("g1_sum", 32'(out_sum_a), 340);
    check("g1_count", 32'(out_count_a), 4);
    check("g1_ovf", 32'(out_overflow_a), 0);
    check("g1_in_ready", 32'(in_ready_a), 0);

    // Back-pressure: result stays put, no product absorbed.
    for (int i = 0; i < 5; i++) begin
      cyc(1, 77, 0, 0, 0);
      settle();
      check("stall_sum", 32'(out_sum_a), 340);
      check("stall_in_ready", 32'(in_ready_a), 0);
    end
    cyc(0, 0, 0, 1, 0);
    settle();
    check("release_in_ready", 32'(in_ready_a), 1);
    check("release_valid", 32'(out_valid_a), 0);

    // Early flush after two accepts.
    cyc(1, 7, 0, 0, 0);
    cyc(1, 9, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    settle();
    check("flush_sum", 32'(out_sum_a), 16);
    check("flush_count", 32'(out_count_a), 2);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    settle();
    check("empty_flush_a", 32'(out_valid_a), 0);
    check("empty_flush_b", 32'(out_valid_b), 0);

    // Flush together with an accept.
    cyc(1, 10, 0, 0, 0);
    cyc(1, 50, 1, 0, 0);
    settle();
    check("flush_acc_sum", 32'(out_sum_a), 60);
    check("flush_acc_count", 32'(out_count_a), 2);
    cyc(0, 0, 0, 1, 0);

    // Narrow instance: eight 225s wrap a 10-bit accumulator.
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 225, 0, 1, 0);
    settle();
    check("wrap_valid", 32'(out_valid_b), 1);
    check("wrap_sum", 32'(out_sum_b), 776);
    check("wrap_count", 32'(out_count_b), 8);
    check("wrap_ovf", 32'(out_overflow_b), 1);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1, 3, 0, 1, 0);
    settle();
    check("small_sum", 32'(out_sum_b), 24);
    check("small_ovf", 32'(out_overflow_b), 0);
    cyc(0, 0, 0, 1, 0);

    // Reset mid-group and during HOLD discards everything.
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 5, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    settle();
    check("rst_mid_ready", 32'(in_ready_a), 1);
    check("rst_mid_valid", 32'(out_valid_a), 0);
    for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 0, 0, 0);
    settle();
    check("post_rst_sum", 32'(out_sum_a), 10);
    cyc(0, 0, 0, 0, 1);
    settle();
    check("rst_hold_valid", 32'(out_valid_a), 0);
    check("rst_hold_ready", 32'(in_ready_a), 1);
    for (int i = 0; i < 4; i++) cyc(1, 20, 0, 0, 0);
    settle();
    check("post_rst2_sum", 32'(out_sum_a), 80);
    check("post_rst2_count", 32'(out_count_a), 4);

    // Random traffic, checked every cycle against the model.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
    end
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
